// File: rtl/calculator_engine.sv
// Keypad calculator core: decimal entry, chained add/sub, shift-add multiply, circular history.
// Define CALC_SIGNED_EN for two's complement arithmetic and signed overflow rules.
module calculator_engine #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [3:0]             key,
   input  logic                   key_valid,
   output logic                   key_ready,
   output logic [WIDTH-1:0]       display,
   output logic                   overflow,
   output logic                   busy,
   output logic [1:0]             pending_op,
   output logic [$clog2(DEPTH):0] hist_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(WIDTH);
   localparam logic [1:0] OP_NONE = 2'b00, OP_ADD = 2'b01, OP_SUB = 2'b10, OP_MUL = 2'b11;
`ifdef CALC_SIGNED_EN
   localparam logic [WIDTH+3:0] DIG_MAX = {5'b0, {(WIDTH-1){1'b1}}};
`else
   localparam logic [WIDTH+3:0] DIG_MAX = {4'b0, {WIDTH{1'b1}}};
`endif

   typedef enum logic [1:0] {IDLE, MULT, MULT_DONE} state_t;
   state_t state, state_nx;

   logic [WIDTH-1:0]   acc, operand, mplier, as_res, mul_res, push_val, mag_a, mag_b;
   logic [1:0]         op_q, chain_op, new_op;
   logic               fresh, push_after, push_en, mul_go, take, as_ov, mul_ov, dig_ov;
   logic [WIDTH-1:0]   hist [DEPTH];
   logic [AW-1:0]      wr_ptr, rec_ptr, oldest, newest;
   logic [AW:0]        count;
   logic [2*WIDTH-1:0] mcand, prod, prod_step;
   logic [CW-1:0]      cnt;
   logic [WIDTH:0]     add_x, sub_x, as_x;
   logic [WIDTH+3:0]   dig_x;

   assign busy       = (state != IDLE);
   assign key_ready  = reset & ~busy;
   assign take       = key_valid & key_ready;
   assign display    = acc;
   assign pending_op = op_q;
   assign hist_count = count;

   assign dig_x  = ({4'b0, acc} << 3) + ({4'b0, acc} << 1) + (WIDTH+4)'(key);
   assign dig_ov = dig_x > DIG_MAX;
   assign add_x  = {1'b0, operand} + {1'b0, acc};
   assign sub_x  = {1'b0, operand} - {1'b0, acc};
   assign as_x   = (op_q == OP_SUB) ? sub_x : add_x;
   assign as_res = as_x[WIDTH-1:0];

   // Final multiply step is folded into MULT_DONE so busy spans exactly WIDTH cycles.
   assign prod_step = prod + (mplier[0] ? mcand : '0);
`ifdef CALC_SIGNED_EN
   logic neg_q;
   assign as_ov = (op_q == OP_SUB)
                ? (operand[WIDTH-1] != acc[WIDTH-1]) && (as_res[WIDTH-1] != operand[WIDTH-1])
                : (operand[WIDTH-1] == acc[WIDTH-1]) && (as_res[WIDTH-1] != operand[WIDTH-1]);
   assign mag_a   = operand[WIDTH-1] ? -operand : operand;
   assign mag_b   = acc[WIDTH-1] ? -acc : acc;
   assign mul_res = neg_q ? -prod_step[WIDTH-1:0] : prod_step[WIDTH-1:0];
   assign mul_ov  = (|prod_step[2*WIDTH-1:WIDTH])
                  | (prod_step[WIDTH-1] & (~neg_q | (|prod_step[WIDTH-2:0])));
`else
   assign as_ov   = as_x[WIDTH];
   assign mag_a   = operand;
   assign mag_b   = acc;
   assign mul_res = prod_step[WIDTH-1:0];
   assign mul_ov  = |prod_step[2*WIDTH-1:WIDTH];
`endif

   assign oldest = wr_ptr - count[AW-1:0];
   assign newest = wr_ptr - AW'(1);

   always_comb begin
      new_op = OP_MUL;
      case (key)
         4'hA:    new_op = OP_ADD;
         4'hB:    new_op = OP_SUB;
         default: new_op = OP_MUL;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      mul_go   = 1'b0;
      case (state)
         IDLE: begin
            if (take && key >= 4'hA && key <= 4'hD && op_q == OP_MUL && !fresh) begin
               mul_go   = 1'b1;
               state_nx = MULT;
            end
         end
         MULT:      if (cnt == CW'(WIDTH-2)) state_nx = MULT_DONE;
         MULT_DONE: state_nx = IDLE;
         default:   state_nx = IDLE;
      endcase
   end

   always_comb begin
      push_en  = 1'b0;
      push_val = acc;
      if (state == MULT_DONE) begin
         push_en  = push_after;
         push_val = mul_res;
      end else if (state == IDLE && take && key == 4'hD && !mul_go) begin
         push_en  = 1'b1;
         push_val = (op_q != OP_NONE && !fresh) ? as_res : acc;
      end
   end

   always_ff @(posedge clock) begin
      if (reset && push_en) hist[wr_ptr] <= push_val;
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         acc <= '0; operand <= '0; op_q <= OP_NONE; chain_op <= OP_NONE;
         fresh <= 1'b1; overflow <= 1'b0; push_after <= 1'b0;
         wr_ptr <= '0; rec_ptr <= '0; count <= '0;
         mcand <= '0; mplier <= '0; prod <= '0; cnt <= '0;
      end else begin
         case (state)
            IDLE: if (take) begin
               if (key <= 4'd9) begin
                  if (fresh) begin
                     acc   <= WIDTH'(key);
                     fresh <= 1'b0;
                  end else if (dig_ov) overflow <= 1'b1;
                  else                 acc <= dig_x[WIDTH-1:0];
               end else if (key <= 4'hD) begin
                  if (key != 4'hD && op_q == OP_NONE) begin
                     operand <= acc;
                     op_q    <= new_op;
                     fresh   <= 1'b1;
                  end else if (key != 4'hD && fresh) begin
                     op_q <= new_op;
                  end else if (!mul_go) begin
                     if (op_q != OP_NONE && !fresh) begin
                        acc      <= as_res;
                        operand  <= as_res;
                        overflow <= overflow | as_ov;
                     end
                     op_q  <= (key == 4'hD) ? OP_NONE : new_op;
                     fresh <= 1'b1;
                  end
               end else if (key == 4'hE) begin
                  if (count != '0) begin
                     acc     <= hist[rec_ptr];
                     fresh   <= 1'b1;
                     rec_ptr <= (rec_ptr == oldest) ? newest : rec_ptr - AW'(1);
                  end
               end else begin
                  acc <= '0; operand <= '0; op_q <= OP_NONE;
                  overflow <= 1'b0; fresh <= 1'b1;
               end
            end
            MULT: begin
               prod   <= prod_step;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + CW'(1);
            end
            MULT_DONE: begin
               acc      <= mul_res;
               operand  <= mul_res;
               overflow <= overflow | mul_ov;
               op_q     <= chain_op;
               fresh    <= 1'b1;
            end
            default: ;
         endcase
         if (mul_go) begin
            mcand      <= {{WIDTH{1'b0}}, mag_a};
            mplier     <= mag_b;
            prod       <= '0;
            cnt        <= '0;
            chain_op   <= (key == 4'hD) ? OP_NONE : new_op;
            push_after <= (key == 4'hD);
         end
         if (push_en) begin
            wr_ptr  <= wr_ptr + AW'(1);
            rec_ptr <= wr_ptr;
            if (count != (AW+1)'(DEPTH)) count <= count + (AW+1)'(1);
         end
      end
   end

`ifdef CALC_SIGNED_EN
   always_ff @(posedge clock) begin
      if (!reset)      neg_q <= 1'b0;
      else if (mul_go) neg_q <= operand[WIDTH-1] ^ acc[WIDTH-1];
   end
`endif

endmodule

// File: tb/tb_calculator_engine.sv
// Scoreboard bench for calculator_engine (WIDTH=32, DEPTH=4): expected display per key
// is queued at drive time and popped once the engine is idle again.
module tb_calculator_engine;
   localparam int W = 32;
   localparam int D = 4;

   logic                 clock = 1'b0;
   logic                 reset = 1'b0;
   logic [3:0]           key = 4'h0;
   logic                 key_valid = 1'b0;
   logic                 key_ready, overflow, busy;
   logic [W-1:0]         display;
   logic [1:0]           pending_op;
   logic [$clog2(D):0]   hist_count;

   int          n_chk = 0;
   int          n_err = 0;
   int          busy_cyc;
   logic        kr_bad;
   logic [W-1:0] exp_q[$];

   always #5 clock = ~clock;

   calculator_engine #(.WIDTH(W), .DEPTH(D)) dut (
      .clock(clock), .reset(reset), .key(key), .key_valid(key_valid),
      .key_ready(key_ready), .display(display), .overflow(overflow), .busy(busy),
      .pending_op(pending_op), .hist_count(hist_count)
   );

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Drive one key at a negedge, wait for acceptance, then wait out any multiply.
   task automatic send(input logic [3:0] k, input logic [W-1:0] exp);
      int n = 0;
      exp_q.push_back(exp);
      key = k;
      key_valid = 1'b1;
      while (!key_ready && n < 200) begin
         @(negedge clock);
         n++;
      end
      if (n >= 200) begin
         n_chk++;
         n_err++;
         $display("FAIL accept_timeout: key %0h not accepted in %0d cycles", k, n);
      end
      @(posedge clock);
      @(negedge clock);
      key_valid = 1'b0;
      busy_cyc = 0;
      kr_bad = 1'b0;
      while (busy && busy_cyc < 200) begin
         if (key_ready) kr_bad = 1'b1;
         busy_cyc++;
         @(negedge clock);
      end
      chk($sformatf("disp_key%0h", k), display, exp_q.pop_front());
   endtask

   task automatic enter(input longint v);
      string s = $sformatf("%0d", v);
      longint cur = 0;
      for (int i = 0; i < s.len(); i++) begin
         cur = cur * 10 + (s.getc(i) - "0");
         send(4'(s.getc(i) - "0"), W'(cur));
      end
   endtask

   initial begin
      repeat (3) @(negedge clock);
      chk("rst_disp", display, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_busy", busy, 0);
      chk("rst_pend", pending_op, 0);
      chk("rst_hist", hist_count, 0);
      chk("rst_ready", key_ready, 0);
      reset = 1'b1;
      @(negedge clock);
      chk("rel_ready", key_ready, 1);

      // 12 + 3 =
      send(4'h1, 1); send(4'h2, 12); send(4'hA, 12); send(4'h3, 3); send(4'hD, 15);
      chk("t1_pend", pending_op, 0);
      chk("t1_hist", hist_count, 1);
      chk("t1_ovf", overflow, 0);

      // 7 * 6 =
      send(4'h7, 7); send(4'hC, 7); send(4'h6, 6); send(4'hD, 42);
      chk("t2_busy_cyc", busy_cyc, 32);
      chk("t2_ready_low", kr_bad, 0);
      chk("t2_hist", hist_count, 2);

      // 5 - 7 = borrows
      send(4'h5, 5); send(4'hB, 5); send(4'h7, 7); send(4'hD, 32'hFFFF_FFFE);
      chk("t3_ovf", overflow, 1);
      send(4'hF, 0);
      chk("t3_clr_ovf", overflow, 0);
      chk("t3_hist", hist_count, 3);

      // chaining: 2 + 3 * 4 evaluated left to right
      send(4'h2, 2); send(4'hA, 2); send(4'h3, 3); send(4'hC, 5); send(4'h4, 4);
      send(4'hD, 20);
      chk("t4_busy_cyc", busy_cyc, 32);
      chk("t4_hist", hist_count, 4);

      // operator replaced: 9 + - 5 =
      send(4'h9, 9); send(4'hA, 9); send(4'hB, 9);
      chk("t5_pend", pending_op, 2'b10);
      send(4'h5, 5); send(4'hD, 4);
      chk("t5_hist_sat", hist_count, 4);

      // entry overflow: extra digit after 2^32-1 is dropped
      enter(64'd4294967295);
      chk("ent_ovf_pre", overflow, 0);
      send(4'h0, 32'hFFFF_FFFF);
      chk("ent_ovf", overflow, 1);
      send(4'hF, 0);

      // multiply overflow: 65536 * 65536
      enter(64'd65536); send(4'hC, 65536); enter(64'd65536); send(4'hD, 0);
      chk("mul_ovf", overflow, 1);
      send(4'hF, 0);

      // key held through a multiply is taken exactly once
      send(4'h3, 3); send(4'hC, 3); send(4'h4, 4);
      exp_q.push_back(12);
      key = 4'hD;
      key_valid = 1'b1;
      @(posedge clock);
      @(negedge clock);
      key = 4'h7;
      exp_q.push_back(7);
      busy_cyc = 0;
      while (busy && busy_cyc < 200) begin
         busy_cyc++;
         @(negedge clock);
      end
      chk("held_busy_cyc", busy_cyc, 32);
      chk("held_mul", display, exp_q.pop_front());
      @(posedge clock);
      @(negedge clock);
      key_valid = 1'b0;
      chk("held_key", display, exp_q.pop_front());
      send(4'h8, 78);
      send(4'hF, 0);

      // reset in the middle of a multiply
      send(4'h3, 3); send(4'hC, 3); send(4'h4, 4);
      key = 4'hD;
      key_valid = 1'b1;
      @(posedge clock);
      @(negedge clock);
      key_valid = 1'b0;
      repeat (9) @(negedge clock);
      chk("mid_busy_pre", busy, 1);
      reset = 1'b0;
      @(negedge clock);
      chk("mid_busy", busy, 0);
      chk("mid_disp", display, 0);
      chk("mid_hist", hist_count, 0);
      chk("mid_pend", pending_op, 0);
      chk("mid_ready", key_ready, 0);
      reset = 1'b1;
      @(negedge clock);

      // history wrap with DEPTH=4 and recall order
      for (int i = 1; i <= 5; i++) begin
         send(4'(i), W'(i));
         send(4'hD, W'(i));
      end
      chk("hist_full", hist_count, 4);
      send(4'hE, 5); send(4'hE, 4); send(4'hE, 3); send(4'hE, 2); send(4'hE, 5);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
